// File: rtl/zero15_pkg.sv
// rtl/zero15_pkg.sv - shared constants, chip code and FSM state type for the zero-15 transmitter
package zero15_pkg;

    localparam int N_CHIPS  = 15;
    localparam int SPC      = 16;
    localparam int SAMPLE_W = 18;

    // Chip code, MSB is the first chip on the air.
    localparam logic [N_CHIPS-1:0] CODE = 15'b111011001010000;

    localparam logic [3:0] LAST_SAMP = 4'(SPC - 1);
    localparam logic [3:0] LAST_CHIP = 4'(N_CHIPS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

endpackage

// File: rtl/zero15_chip_gen.sv
// rtl/zero15_chip_gen.sv - sample/chip counters and chip code lookup
// Counters hold the index of the next sample to emit and wrap to 0 after the symbol's last sample.
module zero15_chip_gen
    import zero15_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic advance,
    output logic chip_pos,
    output logic last
);

    logic [3:0] samp_cnt;
    logic [3:0] chip_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            samp_cnt <= 4'd0;
            chip_cnt <= 4'd0;
        end else if (advance) begin
            if (samp_cnt == LAST_SAMP) begin
                samp_cnt <= 4'd0;
                chip_cnt <= (chip_cnt == LAST_CHIP) ? 4'd0 : chip_cnt + 4'd1;
            end else begin
                samp_cnt <= samp_cnt + 4'd1;
            end
        end
    end

    assign chip_pos = CODE[LAST_CHIP - chip_cnt];
    assign last     = (chip_cnt == LAST_CHIP) && (samp_cnt == LAST_SAMP);

endmodule

// File: rtl/zero15_tx.sv
// rtl/zero15_tx.sv - zero-15 spread-spectrum transmitter, 240 samples per bit
// Define ZERO15_TX_BIPOLAR_EN to send bit 1 as the negated code; otherwise bit 1 is on-off keyed (zeros).
module zero15_tx
    import zero15_pkg::*;
#(
    parameter logic signed [SAMPLE_W-1:0] AMP = 18'sd8192
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       bit_ready,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid,
    output logic                       busy
);

    state_t state, state_nxt;
    logic   cur_bit;
    logic   last_q;
    logic   hs;
    logic   emit;
    logic   bit_sel;
    logic   chip_pos;
    logic   gen_last;
    logic signed [SAMPLE_W-1:0] sample_nxt;

    zero15_chip_gen u_chip_gen (
        .clk      (clk),
        .reset    (reset),
        .advance  (emit),
        .chip_pos (chip_pos),
        .last     (gen_last)
    );

    always_comb begin
        state_nxt  = state;
        bit_ready  = 1'b0;
        hs         = 1'b0;
        emit       = 1'b0;
        bit_sel    = cur_bit;
        sample_nxt = '0;

        // last_q marks that sample 239 is on the output, so a new bit can chain on without a gap.
        bit_ready = !reset && ((state == ST_IDLE) || last_q);
        hs        = bit_valid && bit_ready;
        emit      = hs || ((state == ST_SEND) && !last_q);
        bit_sel   = hs ? bit_in : cur_bit;

        if (hs)
            state_nxt = ST_SEND;
        else if ((state == ST_SEND) && last_q)
            state_nxt = ST_IDLE;

`ifdef ZERO15_TX_BIPOLAR_EN
        sample_nxt = (chip_pos ^ bit_sel) ? AMP : -AMP;
`else
        if (bit_sel)
            sample_nxt = '0;
        else
            sample_nxt = chip_pos ? AMP : -AMP;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cur_bit      <= 1'b0;
            last_q       <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs)
                cur_bit <= bit_in;
            if (emit) begin
                sample_out   <= sample_nxt;
                sample_valid <= 1'b1;
                last_q       <= gen_last;
            end else begin
                sample_out   <= '0;
                sample_valid <= 1'b0;
                last_q       <= 1'b0;
            end
        end
    end

    assign busy = (state == ST_SEND);

endmodule

// File: tb/tb_zero15_tx.sv
// tb/tb_zero15_tx.sv - self-checking bench for zero15_tx (honours ZERO15_TX_BIPOLAR_EN)
module tb_zero15_tx;

    localparam int             AMP_I   = 8192;
    localparam logic [14:0]    TB_CODE = 15'b111011001010000;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               bit_in = 1'b0;
    logic               bit_valid = 1'b0;
    logic               bit_ready;
    logic signed [17:0] sample_out;
    logic               sample_valid;
    logic               busy;

    int checks = 0;
    int errors = 0;

    zero15_tx #(.AMP(18'sd8192)) dut (
        .clk          (clk),
        .reset        (reset),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of the samples still to be shown, filled whole-symbol at handshake.
    int q[$];
    int cur_val   = 0;
    bit cur_valid = 0;
    bit last_hs   = 0;
    bit obs_ready = 0;

    function automatic int ref_sample(input bit b, input int k);
        int sgn;
        int chip;
        chip = k / 16;
        sgn  = TB_CODE[14 - chip] ? AMP_I : -AMP_I;
        if (!b) return sgn;
`ifdef ZERO15_TX_BIPOLAR_EN
        return -sgn;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check ready before the edge, update model, check outputs after.
    task automatic tick(input bit r, input bit v, input bit b);
        bit rdy_exp;
        reset = r; bit_valid = v; bit_in = b;
        #1;
        rdy_exp   = !r && (q.size() == 0);
        obs_ready = bit_ready;
        chk("bit_ready", int'(bit_ready), int'(rdy_exp));
        last_hs = v && rdy_exp;
        @(posedge clk);
        if (r) begin
            q.delete();
            cur_valid = 0;
            cur_val   = 0;
        end else begin
            if (last_hs)
                for (int k = 0; k < 240; k++) q.push_back(ref_sample(b, k));
            if (q.size() > 0) begin
                cur_val   = q.pop_front();
                cur_valid = 1;
            end else begin
                cur_val   = 0;
                cur_valid = 0;
            end
        end
        #1;
        chk("sample_out", int'(sample_out), cur_val);
        chk("sample_valid", int'(sample_valid), int'(cur_valid));
        chk("busy", int'(busy), int'(cur_valid));
    endtask

    typedef struct {
        bit b;
        int idx;
        int exp_out;
        bit exp_valid;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nh, vcnt, gaps, sidx;
        int pulses[$];
        bit started;

        vecs.push_back('{0, 0,    8192, 1});
        vecs.push_back('{0, 47,   8192, 1});
        vecs.push_back('{0, 48,  -8192, 1});
        vecs.push_back('{0, 63,  -8192, 1});
        vecs.push_back('{0, 64,   8192, 1});
        vecs.push_back('{0, 96,  -8192, 1});
        vecs.push_back('{0, 128,  8192, 1});
        vecs.push_back('{0, 239, -8192, 1});
        vecs.push_back('{0, 240,     0, 0});
`ifdef ZERO15_TX_BIPOLAR_EN
        vecs.push_back('{1, 0,   -8192, 1});
        vecs.push_back('{1, 15,  -8192, 1});
        vecs.push_back('{1, 176,  8192, 1});
        vecs.push_back('{1, 239,  8192, 1});
`else
        vecs.push_back('{1, 0,       0, 1});
        vecs.push_back('{1, 100,     0, 1});
        vecs.push_back('{1, 239,     0, 1});
`endif
        vecs.push_back('{1, 240,     0, 0});

        @(posedge clk); #1;
        tick(1, 1, 0);
        tick(1, 0, 0);
        chk("reset_out", int'(sample_out), 0);
        chk("reset_valid", int'(sample_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ready", int'(bit_ready), 0);

        foreach (vecs[i]) begin
            tick(1, 0, 0);
            tick(0, 1, vecs[i].b);
            for (int k = 0; k < vecs[i].idx; k++) tick(0, 0, 0);
            chk("vec_out", int'(sample_out), vecs[i].exp_out);
            chk("vec_valid", int'(sample_valid), int'(vecs[i].exp_valid));
        end
        for (int k = 0; k < 10; k++) tick(0, 0, 0);

        // Bits 0,0,1 with valid held high: one contiguous 720-sample burst.
        nh = 0; vcnt = 0; gaps = 0; sidx = 0; started = 0;
        for (int c = 0; c < 760; c++) begin
            tick(0, nh < 3, nh == 2);
            if (obs_ready && sidx > 0 && sidx - 1 < 719) pulses.push_back(sidx - 1);
            if (last_hs) nh++;
            if (sample_valid) begin
                started = 1; vcnt++; sidx++;
            end else if (started && vcnt < 720) begin
                gaps++;
            end
        end
        chk("b2b_samples", vcnt, 720);
        chk("b2b_gaps", gaps, 0);
        chk("b2b_pulses", pulses.size(), 2);
        if (pulses.size() == 2) begin
            chk("b2b_pulse0", pulses[0], 239);
            chk("b2b_pulse1", pulses[1], 479);
        end

        // Reset in the middle of a symbol aborts it.
        tick(0, 1, 0);
        for (int k = 0; k < 100; k++) tick(0, 0, 0);
        tick(1, 0, 0);
        chk("abort_out", int'(sample_out), 0);
        chk("abort_valid", int'(sample_valid), 0);
        chk("abort_busy", int'(busy), 0);
        tick(0, 0, 0);
        chk("abort_ready", int'(obs_ready), 1);
        vcnt = 0;
        for (int k = 0; k < 200; k++) begin
            tick(0, 0, 0);
            if (sample_valid) vcnt++;
        end
        chk("abort_no_resume", vcnt, 0);

        // bit_valid toggled while busy has no effect.
        vcnt = 0;
        tick(0, 1, 0);
        if (sample_valid) vcnt++;
        for (int k = 0; k < 200; k++) begin
            tick(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (sample_valid) vcnt++;
        end
        for (int k = 0; k < 100; k++) begin
            tick(0, 0, 0);
            if (sample_valid) vcnt++;
        end
        chk("toggle_samples", vcnt, 240);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++)
            tick($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zero15_tx.md
ZERO15_TX -- requirements
Module: zero15_tx

Interface
REQ-001 SHALL have parameter AMP, default 18'sd8192, chip magnitude driven on sample_out.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port bit_in, input, 1, data bit to spread.
REQ-005 SHALL have port bit_valid, input, 1, bit_in is valid this cycle.
REQ-006 SHALL have port bit_ready, output, 1, block accepts bit_in this cycle.
REQ-007 SHALL have port sample_out, output, 18 signed, transmit sample stream feeding the zero-15 matched filter.
REQ-008 SHALL have port sample_valid, output, 1, sample_out carries a symbol sample.
REQ-009 SHALL have port busy, output, 1, a symbol is in progress.

Function
REQ-010 SHALL spread each accepted bit over 15 chips, 16 samples per chip, for 240 samples per symbol.
REQ-011 SHALL use chip code, first-transmitted first: + + + - + + - - + - + - - - - (CODE = 15'b111011001010000, MSB first).
REQ-012 SHALL drive chip '+' as +AMP and '-' as -AMP, each held for exactly 16 consecutive cycles.
REQ-013 SHALL transmit the code unmodified for bit_in=0.
REQ-014 SHALL transmit bit_in=1 per REQ-028/REQ-029.
REQ-015 SHALL implement FSM IDLE -> SEND on handshake (bit_valid & bit_ready); SEND -> IDLE after sample 239 if no new handshake; SEND -> SEND on a handshake at sample 239.
REQ-016 SHALL assert bit_ready in IDLE and on the cycle sample 239 is presented; deassert otherwise.
REQ-017 SHALL present sample 0 of a symbol the cycle after its handshake (latency 1); outputs registered.
REQ-018 SHALL produce back-to-back symbols with no gap when the next handshake occurs at sample 239.
REQ-019 SHALL drive sample_out=0 and sample_valid=0 in IDLE; sample_valid=1 for all 240 samples of every symbol.
REQ-020 SHALL assert busy whenever state is SEND.
REQ-021 SHALL ignore bit_in/bit_valid while bit_ready=0; the bit is captured only at handshake.
REQ-022 SHALL keep internal counters: sample counter 0..15 and chip counter 0..14, both wrapping to 0 at symbol end.
REQ-023 SHALL saturate nothing; AMP limited to 1..131071 so -AMP is representable.

Reset
REQ-024 SHALL on reset force state IDLE, counters 0, sample_out=0, sample_valid=0, busy=0.
REQ-025 SHALL, while reset is high, drive bit_ready=0 and accept no handshake.
REQ-026 SHALL, on reset mid-symbol, abort the symbol; the next cycle after reset release starts in IDLE.
REQ-027 SHALL not retransmit or complete an aborted symbol.

Configuration
REQ-028 SHALL, with ZERO15_TX_BIPOLAR_EN defined, transmit bit_in=1 as the negated code (- - - + - - + + - + - + + + +).
REQ-029 SHALL, without ZERO15_TX_BIPOLAR_EN, transmit bit_in=1 as 240 samples of 0 with sample_valid=1 (on-off keying); timing and handshakes unchanged.

Structure
REQ-030 SHALL place in package zero15_pkg: CODE (15'b111011001010000), N_CHIPS=15, SPC=16, SAMPLE_W=18, FSM state enum.
REQ-031 SHALL use one sub-module zero15_chip_gen: sample/chip counters plus code lookup, outputs current chip sign and last-sample flag.
REQ-032 SHALL keep handshake, FSM and output registers in zero15_tx.

Verification
REQ-033 SHALL check: reset, then one bit 0 with AMP=8192 -> from cycle after handshake, 48 samples +8192, 16 samples -8192, 32 samples +8192, ... per code; sample_valid high 240 cycles, then 0.
REQ-034 SHALL check: bit 1 with macro defined -> first 16 samples -8192, last 64 samples +8192; macro undefined -> 240 samples of 0 with sample_valid=1.
REQ-035 SHALL check: bits 0,0,1 held valid continuously -> 720 contiguous valid samples, bit_ready pulses only at samples 239 and 479.
REQ-036 SHALL check: reset asserted at sample 100 -> next cycle sample_out=0, sample_valid=0, busy=0; bit_ready=1 after release.
REQ-037 SHALL check: bit_valid toggled while busy (bit_ready=0) -> no effect on current symbol, no extra symbol.
REQ-038 SHALL check: output fed through zero15filter -> match_strength peak of 15*(8192>>>4)=7680 at 240 samples after first sample for bit 0.
